window_buffer_kxk: RTL
======================

// Module: window_buffer_kxk
// PURPOSE
//   Parametrised KxK sliding-window register array with built-in row/column
//   sequencing FSM. Sits between the K-tap line buffer and the KxK filter
//   kernels (median, mean, Gaussian, ...), replacing the fixed 3x3/5x5/11x11
//   window buffers. Adds stall tolerance, a synchronous flush and a frame-end
//   pulse aligned with the last window.
// PARAMETERS
//   K     3    window size, odd, 3..11
//   DW    8    pixel width in bits
//   COLS  640  image width in pixels, >= K
//   ROWS  480  image height in pixels, >= K
// PORTS
//   clk           in   1        clock, rising edge
//   rst           in   1        asynchronous reset, active-low
//   clear_i       in   1        synchronous flush to IDLE; priority over valid_i
//   valid_i       in   1        rows_i carries one new column this cycle
//   rows_i        in   K*DW     column taps; row r at [r*DW +: DW], r=0 is the top row
//   win_o         out  K*K*DW   window; (r,c) at [(r*K+c)*DW +: DW], c=0 is the oldest column
//   valid_o       out  1        win_o holds a complete window this cycle
//   frame_done_o  out  1        1-cycle pulse, coincident with the last valid_o of the frame
//   busy_o        out  1        FSM not in IDLE
// BEHAVIOUR
// - Reset (rst=0, async): all win_o bits, col_cnt, row_cnt = 0; valid_o,
//   frame_done_o, busy_o = 0; state = IDLE.
// - Input stream: upstream delivers exactly (ROWS-K+1)*COLS columns per frame,
//   in raster order. Gaps are allowed (valid_i=0 stalls everything; no state change).
// - Shift: on each accepted valid_i, column c takes column c+1 for c < K-1, and
//   column K-1 takes rows_i. Latency is 1 cycle: column accepted at t is visible
//   in win_o at t+1. win_o holds its value when valid_i=0.
// - Counters: col_cnt is $clog2(COLS) bits, wraps COLS-1 -> 0. row_cnt is
//   $clog2(ROWS-K+1)+1 bits and increments on the col wrap. Both advance only
//   on accepted valid_i.
// - FSM:
//     IDLE -> FILL  on valid_i (column 0 of frame).
//     FILL  accepts columns 0..K-2 of a row; valid_o stays 0.
//     FILL -> RUN   when column K-2 is accepted.
//     RUN   for each accepted column col_cnt in K-1..COLS-1: valid_o=1 in the next cycle.
//     RUN -> FILL   on accepting col COLS-1 when row_cnt < ROWS-K.
//     RUN -> IDLE   on accepting col COLS-1 when row_cnt == ROWS-K. The next
//                   cycle has valid_o=1 and frame_done_o=1, and the counters are 0.
//   Stale columns from the previous row stay in the array during FILL. They
//   are never exposed, because valid_o is gated.
// - valid_o and frame_done_o are registered. Each is high for exactly 1 cycle
//   per qualifying accepted column, and 0 otherwise. busy_o = (state != IDLE),
//   registered.
// - Output rate: (COLS-K+1) windows per row; (ROWS-K+1)*(COLS-K+1) per frame.
// - clear_i=1: next cycle state=IDLE, counters=0, valid_o=0, frame_done_o=0.
//   win_o contents are not cleared. A valid_i in the same cycle is dropped.
// - valid_i in the cycle after RUN->IDLE is accepted as column 0 of the next
//   frame (back-to-back frames need no bubble).
// - Async reset mid-frame aborts the frame. No frame_done_o is produced.
// - K=1 and even K are illegal. Elaboration stops with $error.
// TESTING
//   1. K=3,DW=8,COLS=5,ROWS=5; feed 15 columns, rows_i={r,c} pattern each cycle,
//      no gaps -> 9 valid_o pulses. The first one is 3 cycles after the first
//      valid_i, with win_o(r,c)={r,c}. frame_done_o fires only with the 9th.
//   2. Same config, valid_i toggling 1/0 -> identical win_o sequence, and
//      valid_o is never high in a cycle after valid_i=0.
//   3. Row transition: at column 0 and 1 of the 2nd row, valid_o=0. At column 2,
//      win_o(r,0..2) holds only 2nd-row data (no stale columns).
//   4. clear_i asserted after column 7 together with valid_i -> valid_o=0,
//      busy_o=0 next cycle. A fresh 15-column frame then yields 9 windows.
//   5. rst pulled low mid-row -> all outputs 0 immediately (async), no
//      frame_done_o. A fresh frame after release behaves as in test 1.
//   6. K=11,DW=10,COLS=16,ROWS=12 back-to-back 2 frames -> 12 windows each,
//      2 frame_done_o pulses 12 windows apart, pixel (10,10)=newest bottom tap.

Source files
------------

// File: rtl/window_buffer_kxk.sv
// KxK sliding-window register array fed one column per accepted valid_i, with a
// row/column sequencer that flags complete windows and the last window of a frame.
module window_buffer_kxk #(
  parameter int K    = 3,
  parameter int DW   = 8,
  parameter int COLS = 640,
  parameter int ROWS = 480
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              valid_i,
  input  logic [K*DW-1:0]   rows_i,
  output logic [K*K*DW-1:0] win_o,
  output logic              valid_o,
  output logic              frame_done_o,
  output logic              busy_o
);

  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW = $clog2(ROWS - K + 1) + 1;
  localparam logic [CW-1:0] COL_LAST     = CW'(COLS - 1);
  localparam logic [CW-1:0] COL_FILL_END = CW'(K - 2);
  localparam logic [RW-1:0] ROW_LAST     = RW'(ROWS - K);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_RUN  = 2'd2
  } state_t;

  generate
    if (K < 3 || K > 11 || (K % 2) == 0) begin : g_bad_k
      $error("window_buffer_kxk: K must be odd and in 3..11");
    end
    if (COLS < K || ROWS < K) begin : g_bad_dims
      $error("window_buffer_kxk: COLS and ROWS must be >= K");
    end
  endgenerate

  state_t            state;
  logic [CW-1:0]     col_cnt;
  logic [RW-1:0]     row_cnt;
  logic [K*K*DW-1:0] win_p1;
  logic              vld_p1;
  logic              done_p1;
  logic              busy_p1;
  logic              accept;
  logic              col_wrap;
  logic              row_wrap;

  assign accept   = valid_i && !clear_i;
  assign col_wrap = (col_cnt == COL_LAST);
  assign row_wrap = (row_cnt == ROW_LAST);

  // Stage p1: window shift register; oldest column at c=0, newest enters at c=K-1
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      win_p1 <= '0;
    end else if (accept) begin
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) begin
          win_p1[(r*K + c)*DW +: DW] <= win_p1[(r*K + c + 1)*DW +: DW];
        end
        win_p1[(r*K + K - 1)*DW +: DW] <= rows_i[r*DW +: DW];
      end
    end
  end

  // Stage p1: sequencer; flags are registered alongside the window they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      busy_p1 <= 1'b0;
    end else if (clear_i) begin
      state   <= S_IDLE;
      col_cnt <= '0;
      row_cnt <= '0;
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      busy_p1 <= 1'b0;
    end else begin
      vld_p1  <= 1'b0;
      done_p1 <= 1'b0;
      if (valid_i) begin
        col_cnt <= col_wrap ? '0 : col_cnt + 1'b1;
        if (col_wrap) begin
          row_cnt <= row_wrap ? '0 : row_cnt + 1'b1;
        end
        case (state)
          S_IDLE: begin
            state   <= S_FILL;
            busy_p1 <= 1'b1;
          end
          S_FILL: begin
            if (col_cnt == COL_FILL_END) begin
              state <= S_RUN;
            end
          end
          S_RUN: begin
            vld_p1 <= 1'b1;
            if (col_wrap) begin
              if (row_wrap) begin
                state   <= S_IDLE;
                busy_p1 <= 1'b0;
                done_p1 <= 1'b1;
              end else begin
                state <= S_FILL;
              end
            end
          end
          default: begin
            state   <= S_IDLE;
            busy_p1 <= 1'b0;
          end
        endcase
      end
    end
  end

  assign win_o        = win_p1;
  assign valid_o      = vld_p1;
  assign frame_done_o = done_p1;
  assign busy_o       = busy_p1;

endmodule
